// File: rtl/pipe_stage_buffer_mem.sv
// DEPTH x WIDTH payload store for pipe_stage_buffer.
// Synchronous write port and asynchronous read port.
module pipe_stage_buffer_mem #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Payload storage needs no reset; occupancy is tracked by the owner.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage skid FIFO: DEPTH-entry buffer with registered o_ready, bypass on empty,
// flush, occupancy reporting and a sticky overflow flag.
module pipe_stage_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_submit,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_submit,
  input  logic             i_next_ready,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic             ready_q, ready_d;
  logic             submit_q, submit_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overflow_q, overflow_d;

  logic             has_data;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  assign has_data = (count_q != '0);
  assign push     = i_submit & ready_q;
  assign pop      = i_next_ready & (has_data | i_submit);
  // An empty buffer forwards the incoming payload straight to o_data.
  assign bypass   = pop & ~has_data;

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    submit_d   = 1'b0;
    data_d     = data_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;

    if (i_flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      overflow_d = overflow_q | (i_submit & ~ready_q);
      submit_d   = pop;
      if (pop) begin
        if (has_data) begin
          data_d   = mem_rdata;
          rd_ptr_d = rd_ptr_q + PtrW'(1);
        end else begin
          data_d = i_data;
        end
      end
      mem_we = push & ~bypass;
      if (mem_we) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      count_d = count_q + CNT_W'(mem_we) - CNT_W'(pop & has_data);
    end

    ready_d = (count_d < DepthCnt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ready_q    <= 1'b1;
      submit_q   <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ready_q    <= ready_d;
      submit_q   <= submit_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  pipe_stage_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PtrW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (mem_rdata)
  );

  assign o_ready    = ready_q;
  assign o_data     = data_q;
  assign o_submit   = submit_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: DEPTH=2 and DEPTH=4 instances share stimulus and are checked
// every cycle against a queue model, plus literal expectations on the DEPTH=2 instance.
module tb_pipe_stage_buffer;

  localparam int W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         i_submit = 1'b0;
  logic         i_next_ready = 1'b0;
  logic         i_flush = 1'b0;

  logic         rdy2, sub2, ovf2, rdy4, sub4, ovf4;
  logic [W-1:0] dat2, dat4;
  logic [1:0]   cnt2;
  logic [2:0]   cnt4;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pipe_stage_buffer #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_submit     (i_submit),
    .o_ready      (rdy2),
    .o_data       (dat2),
    .o_submit     (sub2),
    .i_next_ready (i_next_ready),
    .i_flush      (i_flush),
    .o_count      (cnt2),
    .o_overflow   (ovf2)
  );

  pipe_stage_buffer #(.WIDTH(W), .DEPTH(4)) u_d4 (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_submit     (i_submit),
    .o_ready      (rdy4),
    .o_data       (dat4),
    .o_submit     (sub4),
    .i_next_ready (i_next_ready),
    .i_flush      (i_flush),
    .o_count      (cnt4),
    .o_overflow   (ovf4)
  );

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of buffered payloads per instance.
  logic [W-1:0] mq [2][$];
  bit           m_sub [2];
  logic [W-1:0] m_data [2];
  bit           m_ovf [2];
  bit           model_ok = 1'b0;
  int           m_dep;
  bit           m_acc;

  always @(posedge i_clk) begin
    for (int k = 0; k < 2; k++) begin
      m_dep = (k == 0) ? 2 : 4;
      if (!i_rst) begin
        mq[k].delete();
        m_sub[k]  = 1'b0;
        m_data[k] = '0;
        m_ovf[k]  = 1'b0;
      end else if (i_flush) begin
        mq[k].delete();
        m_sub[k] = 1'b0;
      end else begin
        m_acc = i_submit && (mq[k].size() < m_dep);
        if (i_submit && !m_acc) m_ovf[k] = 1'b1;
        if (i_next_ready && (mq[k].size() > 0 || m_acc)) begin
          m_sub[k] = 1'b1;
          if (mq[k].size() > 0) begin
            m_data[k] = mq[k].pop_front();
            if (m_acc) mq[k].push_back(i_data);
          end else begin
            m_data[k] = i_data;
          end
        end else begin
          m_sub[k] = 1'b0;
          if (m_acc) mq[k].push_back(i_data);
        end
      end
    end
    if (!i_rst) model_ok = 1'b1;
  end

  always @(negedge i_clk) begin
    if (model_ok) begin
      cmp("d2_ready", int'(rdy2), int'(mq[0].size() < 2));
      cmp("d2_count", int'(cnt2), mq[0].size());
      cmp("d2_submit", int'(sub2), int'(m_sub[0]));
      cmp("d2_data", int'(dat2), int'(m_data[0]));
      cmp("d2_overflow", int'(ovf2), int'(m_ovf[0]));
      cmp("d4_ready", int'(rdy4), int'(mq[1].size() < 4));
      cmp("d4_count", int'(cnt4), mq[1].size());
      cmp("d4_submit", int'(sub4), int'(m_sub[1]));
      cmp("d4_data", int'(dat4), int'(m_data[1]));
      cmp("d4_overflow", int'(ovf4), int'(m_ovf[1]));
    end
  end

  task automatic step(input logic sub, input logic [W-1:0] d, input logic nr, input logic fl);
    i_submit     = sub;
    i_data       = d;
    i_next_ready = nr;
    i_flush      = fl;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1;
    i_rst = 1'b0;
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    i_rst = 1'b1;
    cmp("rst_count", int'(cnt2), 0);
    cmp("rst_ready", int'(rdy2), 1);
    cmp("rst_submit", int'(sub2), 0);
    cmp("rst_data", int'(dat2), 0);
    cmp("rst_overflow", int'(ovf2), 0);

    // Streaming with bypass
    step(1, 16'h00A1, 1, 0);
    cmp("stream_sub1", int'(sub2), 1);
    cmp("stream_dat1", int'(dat2), 'hA1);
    step(1, 16'h00A2, 1, 0);
    cmp("stream_dat2", int'(dat2), 'hA2);
    step(1, 16'h00A3, 1, 0);
    cmp("stream_dat3", int'(dat2), 'hA3);
    cmp("stream_count", int'(cnt2), 0);
    step(0, '0, 1, 0);
    cmp("stream_bubble", int'(sub2), 0);

    // Backpressure fill
    step(1, 16'h0011, 0, 0);
    cmp("fill_count1", int'(cnt2), 1);
    cmp("fill_sub", int'(sub2), 0);
    step(1, 16'h0022, 0, 0);
    cmp("fill_count2", int'(cnt2), 2);
    cmp("fill_ready", int'(rdy2), 0);

    // Overflow
    step(1, 16'h0033, 0, 0);
    cmp("ovf_flag", int'(ovf2), 1);
    cmp("ovf_count", int'(cnt2), 2);

    // Drain
    step(0, '0, 1, 0);
    cmp("drain_dat1", int'(dat2), 'h11);
    cmp("drain_ready", int'(rdy2), 1);
    step(0, '0, 1, 0);
    cmp("drain_dat2", int'(dat2), 'h22);
    cmp("drain_count", int'(cnt2), 0);
    step(0, '0, 1, 0);
    cmp("drain_bubble", int'(sub2), 0);

    // Flush mid-stream
    step(1, 16'h0055, 0, 0);
    step(1, 16'h0066, 0, 0);
    step(1, 16'h0044, 0, 1);
    cmp("flush_sub", int'(sub2), 0);
    cmp("flush_count", int'(cnt2), 0);
    cmp("flush_ready", int'(rdy2), 1);
    cmp("flush_ovf", int'(ovf2), 1);
    cmp("flush_data_hold", int'(dat2), 'h22);
    step(0, '0, 1, 0);
    cmp("flush_no_emit", int'(sub2), 0);

    // Reset mid-operation
    step(1, 16'h0077, 0, 0);
    cmp("prerst_count", int'(cnt2), 1);
    i_rst = 1'b0;
    step(0, '0, 0, 0);
    i_rst = 1'b1;
    cmp("midrst_count", int'(cnt2), 0);
    cmp("midrst_ovf", int'(ovf2), 0);
    cmp("midrst_sub", int'(sub2), 0);
    cmp("midrst_data", int'(dat2), 0);

    // Randomized traffic, mostly honouring the DEPTH=4 ready
    for (int i = 0; i < 800; i++) begin
      logic s;
      s = ($urandom_range(0, 3) != 0) && (rdy4 || ($urandom_range(0, 15) == 0));
      step(s, W'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 60) == 0));
    end
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised pipeline-stage wrapper that holds WIDTH-bit payloads (decoded control bundles, immediates, prediction bits) between two CPU pipeline stages.
- Generalises the single-entry "don't overwrite buffer" latch into a DEPTH-entry skid FIFO.
- o_ready is registered, so the upstream ready path no longer depends combinationally on i_next_ready.
- Adds occupancy reporting, flush, and a sticky protocol-violation flag. It sits between fetch→decode, decode→execute, or any other stage pair.

Parameters:
- WIDTH, 64, payload width in bits (≥1).
- DEPTH, 2, buffer entries; a power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- i_clk  in  1  clock, all logic on the rising edge.
- i_rst  in  1  synchronous, active-low reset (0 = reset).
- i_data  in  WIDTH  payload from the upstream stage.
- i_submit  in  1  upstream transfer strobe; legal only while o_ready=1.
- o_ready  out  1  buffer can accept i_submit this cycle.
- o_data  out  WIDTH  payload to the downstream stage; valid when o_submit=1.
- o_submit  out  1  one-cycle downstream transfer strobe.
- i_next_ready  in  1  downstream can accept a transfer next cycle.
- i_flush  in  1  discard all buffered and in-flight payloads.
- o_count  out  CNT_W  current buffered entries (excludes o_data).
- o_overflow  out  1  sticky; set when i_submit arrives while o_ready=0.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - count=0, rd_ptr=0, wr_ptr=0, o_submit=0, o_overflow=0, o_data=0.
  - o_ready reads 1 in the first cycle after reset.
  - Reset overrides every other input.
- o_ready is driven purely from a register: 1 iff count<DEPTH. It has no combinational path from i_next_ready, i_submit or i_flush.
- Per cycle (not flushing):
  - pop = i_next_ready & (count>0 | i_submit).
  - push = i_submit & o_ready.
- Output strobe:
  - o_submit<=pop by default; it is 0 on any cycle without a pop (bubble).
  - o_data is updated only on pop and holds its value otherwise.
- Pop source:
  - If count>0, o_data<=mem[rd_ptr], rd_ptr++.
  - If count==0 and i_submit, o_data<=i_data (bypass; entry is never written to mem). Latency input→o_submit is 1 cycle.
- Push destination: if push and not bypassed, mem[wr_ptr]<=i_data, wr_ptr++.
- Count update: count += (push & ~bypass) − (pop & count>0).
- Full with simultaneous pop: push is not accepted, because o_ready was 0. The freed slot appears as o_ready=1 next cycle.
- Empty with i_submit and i_next_ready=0: payload is stored, count→1, and o_submit=0.
- Pointers wrap modulo DEPTH.
- Illegal push:
  - i_submit & ~o_ready & ~i_flush sets o_overflow.
  - The payload is dropped and state is otherwise unchanged.
  - o_overflow clears only on reset.
- Flush:
  - i_flush=1 dominates: count<=0, rd_ptr<=wr_ptr<=0, o_submit<=0.
  - A same-cycle i_submit is dropped and does not set o_overflow.
  - o_data holds its value.
  - o_ready is 1 the cycle after a flush.
- Any nonzero i_data is legal; the block never inspects the payload.

Decomposition:
- No new package. Payload widths come from config.v constants at instantiation (e.g. WIDTH = sum of decode control field widths).
- One natural sub-module: pipe_stage_buffer_mem, a DEPTH×WIDTH register array with a write port and an asynchronous read at rd_ptr.
- Pointer and count logic stays in the top module.

Test Plan:
- Streaming: i_next_ready=1, submit 0xA1,0xA2,0xA3 on consecutive cycles → o_submit high for 3 cycles, starting one cycle after the first submit, with o_data A1,A2,A3; o_count stays 0.
- Backpressure fill (DEPTH=2): i_next_ready=0, submit 0x11,0x22 → o_count=2 and o_ready=0. Then raise i_next_ready → o_data 0x11 then 0x22 on successive cycles, and o_ready=1 after the first pop.
- Overflow: with full buffer, i_submit=1 data 0x33 → o_overflow=1, o_count stays 2, and 0x33 never appears on o_data.
- Flush mid-stream: o_count=2, assert i_flush with i_submit=1 data 0x44 → next cycle o_submit=0, o_count=0, o_ready=1, o_overflow unchanged. 0x44 is never emitted.
- Reset mid-operation: o_count=1 and o_overflow=1, hold i_rst=0 for one cycle → o_count=0, o_overflow=0, o_submit=0, o_data=0.
- Wrap-around (DEPTH=4): 10 pushes interleaved with random i_next_ready → every payload is emitted exactly once, in order, and o_count never exceeds 4.
